softusb_hostmbox: RTL
=====================

# softusb_hostmbox

Host-to-microcontroller mailbox for the softusb core. The host CPU pushes 32-bit command words through the CSR bus into a small FIFO. The softusb microcontroller drains them byte-wise through its I/O bus and receives a level interrupt while words are pending. It complements the existing microcontroller-to-host IRQ path with a host-to-microcontroller data path, all in one clock domain.

## Interface
- csr_addr, 4'h0, CSR bank select compared against csr_a[13:10]
- depth_log2, 2, FIFO depth = 2^depth_log2 words (default 4)

- sys_clk  in  1  single clock for CSR and I/O sides
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- csr_a  in  14  CSR address; [13:10] bank, [1:0] register
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- io_a  in  6  microcontroller I/O address
- io_re  in  1  I/O read strobe (informational, reads have no side effects)
- io_we  in  1  I/O write strobe
- io_di  in  8  I/O write data
- io_do  out  8  I/O read data, combinational from io_a
- usb_irq  out  1  interrupt to the microcontroller, level

One clock (sys_clk); reset is asynchronous and active-low (sys_rst_n).

## Operation
- Storage: 2^depth_log2 x 32 register FIFO with wr_ptr/rd_ptr of depth_log2 bits (wrap naturally) and level of depth_log2+1 bits. full = (level == 2^depth_log2); empty = (level == 0).
- CSR map, selected when csr_a[13:10]==csr_addr:
  - reg 0: a write pushes csr_di. A read returns free slots (2^depth_log2 - level).
  - reg 1: status read as {level at [8:2], overflow [1], empty [0]}. Writing with csr_di[1]=1 clears overflow.
  - reg 2: pop counter, 16 bits, wraps. Read-only.
  - reg 3: reads 0. Writes are ignored.
- I/O map:
  - 0x18 status: {level[3:1], nonempty[0]}, upper bits 0.
  - 0x19–0x1C: head word bytes 0–3, little-endian (0x19 = bits [7:0]). Reads 0 when empty.
  - 0x1D: any write pops the head word.
  - 0x1E: bit0 = irq_en, read/write.
  - Other addresses read 0.
- usb_irq = irq_en & ~empty.
- Push when full: data is dropped, pointers are unchanged, and overflow is set (sticky).
- Pop when empty: ignored, and the pop counter does not increment.
- Push and pop in the same cycle:
  - Not empty: both take effect, level unchanged.
  - Full: pop takes effect and push is accepted, so level is unchanged and overflow is not set.
  - Empty: push only, level becomes 1.
- Overflow set and a CSR clear in the same cycle: set wins.

## Timing
- Reset values: csr_do=0, io_do=0 (empty, irq_en=0), usb_irq=0, level=0, pointers=0, overflow=0, pop counter=0, irq_en=0.
- CSR read: csr_do is valid the cycle after csr_a is presented. It is 0 when the bank is not selected, following the standard CSR slave convention.
- CSR push: the word is visible at I/O 0x19–0x1C and level increments on the edge where csr_we is sampled. usb_irq rises the next cycle if irq_en=1.
- I/O pop: the next word is visible at 0x19–0x1C the cycle after io_we@0x1D. usb_irq falls the same edge the last word is popped.
- Status and counter reads reflect state after the previous edge. A CSR read concurrent with a push returns the pre-push value.
- Reset asserted mid-transfer: the FIFO contents are discarded immediately (asynchronously) and all outputs return to their reset values.

## Test plan
- Reset, then read CSR regs 0/1/2 -> 4, 0x00000001, 0. Read io 0x18 -> 0x00. usb_irq=0.
- Write io 0x1E=1, push 0xDEADBEEF -> usb_irq=1 the next cycle. io 0x19..0x1C read EF, BE, AD, DE. Write 0x1D -> usb_irq=0, pop counter=1.
- Push 5 words 0x11..0x15 -> CSR reg1 = 0x12 (level 4, overflow 1). Pops return 0x11..0x14 in order. Write reg1 with 0x2 -> overflow clears.
- FIFO full and push+pop in the same cycle -> level stays 4, overflow stays 0, and the new word is read last.
- Empty FIFO, pop -> pop counter unchanged, level 0. Run 2^16 push/pop pairs -> counter wraps to 0. Pointers wrap with data intact.
- Assert sys_rst_n low mid-sequence with 3 words queued -> outputs go to reset values asynchronously. After release, reg1 reads 0x1.

Source files
------------

// File: rtl/softusb_hostmbox_if.sv
// Bus bundle between the host CSR port, the softusb I/O port and the mailbox.
interface softusb_hostmbox_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic [5:0]  io_a;
    logic        io_re;
    logic        io_we;
    logic [7:0]  io_di;
    logic [7:0]  io_do;

    modport master (
        output csr_a, csr_we, csr_di,
        input  csr_do,
        output io_a, io_re, io_we, io_di,
        input  io_do
    );

    modport slave (
        input  csr_a, csr_we, csr_di,
        output csr_do,
        input  io_a, io_re, io_we, io_di,
        output io_do
    );
endinterface

// File: rtl/softusb_hostmbox.sv
// Host-to-microcontroller mailbox: the host pushes 32-bit words over CSR, the
// softusb microcontroller drains them byte-wise over I/O and gets a level IRQ.
module softusb_hostmbox #(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int         depth_log2 = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    softusb_hostmbox_if.slave bus,
    output logic              usb_irq
);
    localparam int DEPTH = 1 << depth_log2;
    localparam int LW    = depth_log2 + 1;

    localparam logic [5:0] IO_STATUS = 6'h18;
    localparam logic [5:0] IO_HEAD0  = 6'h19;
    localparam logic [5:0] IO_HEAD1  = 6'h1A;
    localparam logic [5:0] IO_HEAD2  = 6'h1B;
    localparam logic [5:0] IO_HEAD3  = 6'h1C;
    localparam logic [5:0] IO_POP    = 6'h1D;
    localparam logic [5:0] IO_IRQEN  = 6'h1E;

    typedef enum logic [1:0] {
        REG_PUSH   = 2'd0,
        REG_STATUS = 2'd1,
        REG_POPCNT = 2'd2,
        REG_RSVD   = 2'd3
    } csr_reg_e;

    logic [31:0]           mem [DEPTH];
    logic [depth_log2-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic [2:0]            level3;
    logic                  overflow, irq_en;
    logic [15:0]           pop_cnt;
    logic                  full, empty, csr_sel;
    csr_reg_e              csr_reg;
    logic                  push_req, pop_req, do_push, do_pop, ovf_set, ovf_clr;
    logic [31:0]           head;
    logic                  unused_bits;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign level3   = 3'(level);
    assign head     = mem[rd_ptr];
    assign csr_sel  = (bus.csr_a[13:10] == csr_addr);
    assign csr_reg  = csr_reg_e'(bus.csr_a[1:0]);

    assign push_req = csr_sel && bus.csr_we && (csr_reg == REG_PUSH);
    assign pop_req  = bus.io_we && (bus.io_a == IO_POP);
    assign do_pop   = pop_req && !empty;
    // A full FIFO still takes the push when a pop frees the head slot the same cycle.
    assign do_push  = push_req && (!full || do_pop);
    assign ovf_set  = push_req && full && !do_pop;
    assign ovf_clr  = csr_sel && bus.csr_we && (csr_reg == REG_STATUS) && bus.csr_di[1];

    assign usb_irq  = irq_en && !empty;

    assign unused_bits = ^{bus.io_re, bus.csr_a[9:2], bus.io_di[7:1]};

    // NOTE: storage is not reset; an empty level masks stale words, so clearing
    // level/pointers discards the contents and keeps the array in plain RAM cells.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= bus.csr_di;
    end

    // NOTE: every register here uses <= so all updates see the pre-edge state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
            pop_cnt    <= '0;
            bus.csr_do <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pop_cnt <= pop_cnt + 16'd1;
            end

            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (bus.io_we && (bus.io_a == IO_IRQEN)) irq_en <= bus.io_di[0];

            bus.csr_do <= '0;
            if (csr_sel) begin
                case (csr_reg)
                    REG_PUSH:   bus.csr_do <= 32'(DEPTH) - 32'(level);
                    REG_STATUS: bus.csr_do <= (32'(level) << 2) | {30'd0, overflow, empty};
                    REG_POPCNT: bus.csr_do <= {16'd0, pop_cnt};
                    default:    bus.csr_do <= '0;
                endcase
            end
        end
    end

    // NOTE: io_do gets a default before the case so no path leaves it unassigned.
    always_comb begin
        bus.io_do = '0;
        case (bus.io_a)
            IO_STATUS: bus.io_do = {4'd0, level3, !empty};
            IO_HEAD0:  if (!empty) bus.io_do = head[7:0];
            IO_HEAD1:  if (!empty) bus.io_do = head[15:8];
            IO_HEAD2:  if (!empty) bus.io_do = head[23:16];
            IO_HEAD3:  if (!empty) bus.io_do = head[31:24];
            IO_IRQEN:  bus.io_do = {7'd0, irq_en};
            default:   bus.io_do = '0;
        endcase
    end
endmodule
